multicycle_cpu: RTL

Multi-cycle MIPS-subset core that replaces the single-cycle datapath on the board top. Each instruction is split into FETCH/DECODE/EXEC/MEM/WB states. It shares one external memory port for instructions and data, with a req/ready handshake so memories with wait states can be attached. It adds run/single-step control, halt on illegal opcode, an instruction counter, and a debug register read port that feeds the existing 7-segment and LED debug logic.

---
 rtl/multicycle_cpu.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared
// instruction/data memory port with a req/ready handshake, run/step control and debug taps.
module multicycle_cpu #(
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   input  logic [4:0]        test_addr,
   output logic [31:0]       test_out,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  instr_count,
   output logic              halted,
   output logic [4:0]        itype
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd7
   } state_t;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  pc_reg, pc_next;
   logic [CNT_W-1:0]   count_reg;
   logic [31:0]        ir_reg, a_reg, b_reg, alu_reg, mdr_reg;
   logic               ir_valid_reg;
   logic [31:0]        rf [32];

   logic               mem_req_next, mem_we_next;
   logic [ADDR_W-1:0]  mem_addr_next;
   logic [31:0]        mem_wdata_next;
   logic               retire, ir_load, ab_load, alu_load, mdr_load, rf_we;

   // Instruction field decode of the latched IR
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wr_addr;
   logic [31:0] imm_sext, operand_b, alu_out, wr_data;
   logic        is_r, is_lw, is_sw, is_beq, is_j, is_addi, funct_ok, legal, mem_ack;
   logic [ADDR_W-1:0] jump_target, branch_target;

   assign opcode   = ir_reg[31:26];
   assign rs       = ir_reg[25:21];
   assign rt       = ir_reg[20:16];
   assign rd       = ir_reg[15:11];
   assign funct    = ir_reg[5:0];
   assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

   assign is_r     = (opcode == 6'h00);
   assign is_lw    = (opcode == 6'h23);
   assign is_sw    = (opcode == 6'h2B);
   assign is_beq   = (opcode == 6'h04);
   assign is_j     = (opcode == 6'h02);
   assign is_addi  = (opcode == 6'h08);
   assign funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                     (funct == 6'h25) || (funct == 6'h2A);
   assign legal    = (is_r && funct_ok) || is_lw || is_sw || is_beq || is_j || is_addi;

   assign mem_ack       = mem_req && mem_ready;
   assign jump_target   = {ir_reg[ADDR_W-3:0], 2'b00};
   assign branch_target = pc_reg + {imm_sext[ADDR_W-3:0], 2'b00};
   assign wr_addr       = is_r ? rd : rt;
   assign wr_data       = is_lw ? mdr_reg : alu_out_hold();

   function automatic logic [31:0] alu_out_hold();
      return alu_reg;
   endfunction

   assign operand_b = is_r ? b_reg : imm_sext;

   always_comb begin
      alu_out = a_reg + operand_b;
      if (is_r) begin
         case (funct)
            6'h22:   alu_out = a_reg - b_reg;
            6'h24:   alu_out = a_reg & b_reg;
            6'h25:   alu_out = a_reg | b_reg;
            6'h2A:   alu_out = ($signed(a_reg) < $signed(b_reg)) ? 32'd1 : 32'd0;
            default: alu_out = a_reg + b_reg;
         endcase
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (run || step) state_next = S_FETCH;
         S_FETCH:  if (mem_ack) state_next = S_DECODE;
         S_DECODE: begin
            if (!legal)    state_next = S_HALT;
            else if (is_j) state_next = run ? S_FETCH : S_IDLE;
            else           state_next = S_EXEC;
         end
         S_EXEC: begin
            if (is_beq)              state_next = run ? S_FETCH : S_IDLE;
            else if (is_lw || is_sw) state_next = S_MEM;
            else                     state_next = S_WB;
         end
         S_MEM: begin
            if (mem_ack) state_next = is_sw ? (run ? S_FETCH : S_IDLE) : S_WB;
         end
         S_WB:     state_next = run ? S_FETCH : S_IDLE;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   // Output / datapath control; memory outputs are precomputed from the next state
   always_comb begin
      pc_next  = pc_reg;
      retire   = 1'b0;
      ir_load  = 1'b0;
      ab_load  = 1'b0;
      alu_load = 1'b0;
      mdr_load = 1'b0;
      rf_we    = 1'b0;
      case (state_reg)
         S_FETCH: begin
            if (mem_ack) begin
               ir_load = 1'b1;
               pc_next = pc_reg + ADDR_W'(4);
            end
         end
         S_DECODE: begin
            ab_load = 1'b1;
            if (legal && is_j) begin
               pc_next = jump_target;
               retire  = 1'b1;
            end
         end
         S_EXEC: begin
            alu_load = 1'b1;
            if (is_beq) begin
               retire = 1'b1;
               if (a_reg == b_reg) pc_next = branch_target;
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               if (is_sw) retire   = 1'b1;
               else       mdr_load = 1'b1;
            end
         end
         S_WB: begin
            retire = 1'b1;
            rf_we  = (wr_addr != 5'd0);
         end
         default: ;
      endcase

      mem_req_next   = (state_next == S_FETCH) || (state_next == S_MEM);
      mem_we_next    = (state_next == S_MEM) && is_sw;
      mem_wdata_next = ((state_next == S_MEM) && is_sw) ? b_reg : 32'd0;
      if (state_next == S_FETCH)    mem_addr_next = pc_next;
      else if (state_next == S_MEM) mem_addr_next = alu_out[ADDR_W-1:0];
      else                          mem_addr_next = '0;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_reg       <= '0;
         count_reg    <= '0;
         ir_reg       <= '0;
         ir_valid_reg <= 1'b0;
         a_reg        <= '0;
         b_reg        <= '0;
         alu_reg      <= '0;
         mdr_reg      <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         pc_reg    <= pc_next;
         mem_req   <= mem_req_next;
         mem_we    <= mem_we_next;
         mem_addr  <= mem_addr_next;
         mem_wdata <= mem_wdata_next;
         if (retire) count_reg <= count_reg + CNT_W'(1);
         if (ir_load) begin
            ir_reg       <= mem_rdata;
            ir_valid_reg <= 1'b1;
         end
         if (ab_load) begin
            a_reg <= (rs == 5'd0) ? 32'd0 : rf[rs];
            b_reg <= (rt == 5'd0) ? 32'd0 : rf[rt];
         end
         if (alu_load) alu_reg <= alu_out;
         if (mdr_load) mdr_reg <= mem_rdata;
      end
   end

   // Register file; r0 is never written so it stays zero
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (rf_we) begin
         rf[wr_addr] <= wr_data;
      end
   end

   assign test_out    = (test_addr == 5'd0) ? 32'd0 : rf[test_addr];
   assign pc          = pc_reg;
   assign state       = state_reg;
   assign instr_count = count_reg;
   assign halted      = (state_reg == S_HALT);
   assign itype       = ir_valid_reg ? {is_r, is_lw, is_sw, is_beq, is_j} : 5'd0;

endmodule
